// File: rtl/matrix_sniffer.sv
// Passive sniffer for a shift-register/latch serial bus, exposing captured frames over Wishbone.
// Optional latch counter at address 9 is built when MATRIX_SNIFFER_STATS_EN is defined.
module matrix_sniffer #(
  parameter int unsigned CHAIN_BITS  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_matrix_clk,
  input  logic        i_matrix_latch,
  input  logic        i_matrix_mosi,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_addr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_wdata,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_rdata
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned FRAMES = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, slat_q, slat_d, smosi_q, smosi_d;
  logic                   hclk_q, hclk_d, hlat_q, hlat_d;
  logic [CHAIN_BITS-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic                   err_q, err_d;
  logic [31:0]            frame_q [FRAMES];
  logic [31:0]            frame_d [FRAMES];
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;

  logic        shift_edge_c, latch_edge_c, clear_c, req_c;
  logic [31:0] latch_cnt_c;
  logic        unused_c;

  assign shift_edge_c = sclk_q[SYNC_STAGES-1] & ~hclk_q;
  assign latch_edge_c = slat_q[SYNC_STAGES-1] & ~hlat_q;
  assign req_c        = i_wb_cyc & i_wb_stb;
  assign clear_c      = req_c & i_wb_we & (i_wb_addr == 4'd8) & i_wb_sel[0] & i_wb_wdata[0];
  assign unused_c     = ^{i_wb_sel[3:1], i_wb_wdata[31:1]};

  // Edge capture, frame storage and Wishbone response
  always_comb begin
    sclk_d   = {sclk_q[SYNC_STAGES-2:0], i_matrix_clk};
    slat_d   = {slat_q[SYNC_STAGES-2:0], i_matrix_latch};
    smosi_d  = {smosi_q[SYNC_STAGES-2:0], i_matrix_mosi};
    hclk_d   = sclk_q[SYNC_STAGES-1];
    hlat_d   = slat_q[SYNC_STAGES-1];
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    err_d    = err_q;
    frame_d  = frame_q;
    ack_d    = req_c;
    rdata_d  = '0;

    if (shift_edge_c) begin
      sr_d  = CHAIN_BITS'({sr_q, smosi_q[SYNC_STAGES-1]});
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
    // Latch sees the post-shift word and count when both edges coincide
    if (latch_edge_c) begin
      frame_d[wptr_q] = 32'(sr_d);
      wptr_d          = wptr_q + PTR_W'(1);
      if (cnt_d != CNT_W'(CHAIN_BITS)) err_d = 1'b1;
      cnt_d           = '0;
    end
    if (clear_c) begin
      err_d  = 1'b0;
      wptr_d = '0;
      cnt_d  = '0;
    end

    if (req_c && !i_wb_we) begin
      case (i_wb_addr)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                 rdata_d = frame_q[i_wb_addr[PTR_W-1:0]];
        4'd8:    rdata_d = {16'h0, err_q, 1'b0, cnt_q, 5'h0, wptr_q};
        4'd9:    rdata_d = latch_cnt_c;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_q  <= '0;
      slat_q  <= '0;
      smosi_q <= '0;
      hclk_q  <= 1'b0;
      hlat_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < FRAMES; i++) frame_q[i] <= '0;
    end else begin
      sclk_q  <= sclk_d;
      slat_q  <= slat_d;
      smosi_q <= smosi_d;
      hclk_q  <= hclk_d;
      hlat_q  <= hlat_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < FRAMES; i++) frame_q[i] <= frame_d[i];
    end
  end

`ifdef MATRIX_SNIFFER_STATS_EN
  logic [31:0] lcnt_q, lcnt_d;

  always_comb begin
    lcnt_d = lcnt_q;
    if (latch_edge_c) lcnt_d = lcnt_q + 32'd1;
    if (clear_c)      lcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) lcnt_q <= '0;
    else        lcnt_q <= lcnt_d;
  end

  assign latch_cnt_c = lcnt_q;
`else
  assign latch_cnt_c = '0;
`endif

  assign o_wb_ack   = ack_q;
  assign o_wb_rdata = rdata_q;
  assign o_wb_stall = 1'b0;

endmodule
